// File: rtl/ej32_boot_loader.sv
// ej32_boot_loader
//   Copies the boot image from a synchronous ROM into RAM, BW bytes per beat.
//   The RAM side may stall the copy with ram_rdy. At the end it checks an 8-bit
//   additive checksum. On a match it enables the decoder at COLD. On a mismatch it
//   raises err and keeps the core held off. A start pulse in DONE or ERR re-runs
//   the whole load.
//
// Ports
//   clk      in   1        clock, rising edge
//   rst      in   1        asynchronous reset, active low
//   start    in   1        reload request, honoured only in DONE or ERR
//   chk_exp  in   8        expected mod-256 sum of all image bytes
//   rom_en   out  1        ROM read enable
//   rom_a    out  ASZ      ROM byte address, steps by BW
//   rom_d    in   8*BW     ROM data, one cycle after rom_a/rom_en, little-endian lanes
//   ram_we   out  1        RAM write strobe, covers BW bytes
//   ram_a    out  ASZ      RAM byte address (MEM0 + image offset of the beat)
//   ram_d    out  8*BW     RAM write data
//   ram_rdy  in   1        RAM accepts the write when ram_we & ram_rdy
//   busy     out  1        high while loading or checking
//   dc_en    out  1        decoder enable, high only in DONE
//   boot_p   out  ASZ      decoder start address, COLD in DONE, otherwise 0
//   err      out  1        checksum mismatch, high only in ERR
module ej32_boot_loader #(
  parameter int unsigned    ASZ      = 17,
  parameter int unsigned    BW       = 1,
  parameter int unsigned    ROM_SZ   = 8192,
  parameter int unsigned    ROM_WAIT = 3,
  parameter logic [ASZ-1:0] MEM0     = '0,
  parameter logic [ASZ-1:0] COLD     = '0,
  parameter bit             CHK_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      chk_exp,
  output logic            rom_en,
  output logic [ASZ-1:0]  rom_a,
  input  logic [8*BW-1:0] rom_d,
  output logic            ram_we,
  output logic [ASZ-1:0]  ram_a,
  output logic [8*BW-1:0] ram_d,
  input  logic            ram_rdy,
  output logic            busy,
  output logic            dc_en,
  output logic [ASZ-1:0]  boot_p,
  output logic            err
);

  // The issue address carries one extra bit so that ROM_SZ == 2**ASZ can still
  // be told apart from address 0 when issuing stops.
  localparam int unsigned    AW       = ASZ + 1;
  localparam int unsigned    CW       = (ROM_WAIT > 0) ? $clog2(ROM_WAIT + 1) : 1;
  localparam logic [AW-1:0]  A_END    = AW'(ROM_SZ);
  localparam logic [AW-1:0]  A_STEP   = AW'(BW);
  localparam logic [ASZ-1:0] A_LAST   = ASZ'(ROM_SZ - BW);
  localparam logic [CW-1:0]  CNT_INIT = CW'(ROM_WAIT);

  typedef enum logic [2:0] {
    S_WAIT,
    S_COPY,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [AW-1:0]  issue_a_reg, issue_a_next;
  logic           pend_reg, pend_next;
  logic [ASZ-1:0] pend_a_reg, pend_a_next;
  logic [7:0]     sum_reg, sum_next;

  logic           issue_vld;
  logic           advance;
  logic [7:0]     lane [BW];
  logic [7:0]     beat_sum;

  // Split the beat into its byte lanes for the checksum.
  genvar gi;
  generate
    for (gi = 0; gi < BW; gi++) begin : g_lane
      assign lane[gi] = rom_d[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    beat_sum = 8'h00;
    for (int i = 0; i < BW; i++) begin
      beat_sum = beat_sum + lane[i];
    end
  end

  assign issue_vld = (issue_a_reg != A_END);
  // The write stage moves on when it is empty or its beat is being accepted.
  assign advance   = !pend_reg || ram_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_WAIT;
      cnt_reg     <= CNT_INIT;
      issue_a_reg <= '0;
      pend_reg    <= 1'b0;
      pend_a_reg  <= '0;
      sum_reg     <= 8'h00;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      issue_a_reg <= issue_a_next;
      pend_reg    <= pend_next;
      pend_a_reg  <= pend_a_next;
      sum_reg     <= sum_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    issue_a_next = issue_a_reg;
    pend_next    = pend_reg;
    pend_a_next  = pend_a_reg;
    sum_next     = sum_reg;
    case (state_reg)
      S_WAIT: begin
        if (cnt_reg == '0) begin
          state_next   = S_COPY;
          issue_a_next = '0;
          pend_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_COPY: begin
        if (advance) begin
          pend_next = issue_vld;
          if (issue_vld) begin
            pend_a_next  = issue_a_reg[ASZ-1:0];
            issue_a_next = issue_a_reg + A_STEP;
          end
          // advance with pend set means the pending beat was accepted
          if (pend_reg) begin
            sum_next = sum_reg + beat_sum;
            if (pend_a_reg == A_LAST) begin
              state_next = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        state_next = (!CHK_EN || (sum_reg == chk_exp)) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_next   = S_WAIT;
          cnt_next     = CNT_INIT;
          issue_a_next = '0;
          pend_next    = 1'b0;
          pend_a_next  = '0;
          sum_next     = 8'h00;
        end
      end
      default: state_next = S_WAIT;
    endcase
  end

  // rom_en drops while the write stage is stalled, so an enable-gated ROM keeps
  // presenting the stalled beat on rom_d until RAM takes it.
  assign rom_en = (state_reg == S_COPY) && issue_vld && advance;
  assign rom_a  = issue_a_reg[ASZ-1:0];
  assign ram_we = (state_reg == S_COPY) && pend_reg;
  assign ram_a  = MEM0 + pend_a_reg;
  assign ram_d  = rom_d;
  assign busy   = (state_reg == S_WAIT) || (state_reg == S_COPY) || (state_reg == S_CHECK);
  assign dc_en  = (state_reg == S_DONE);
  assign err    = (state_reg == S_ERR);
  assign boot_p = (state_reg == S_DONE) ? COLD : '0;

endmodule

// File: tb/tb_ej32_boot_loader.sv
// Bench for ej32_boot_loader: three instances sharing clock and reset.
//   u_dut1: BW=1, MEM0=0       (timing, stall, checksum error/reload, reset abort)
//   u_dut4: BW=4               (wide beats, lane order)
//   u_dut6: BW=1, MEM0='h1000, COLD='h40 (offset addresses, start ignored in COPY)
// Each ROM holds byte[i]=i for i=0..15, and reads only when rom_en is high.
module tb_ej32_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT 1 ----------------
  logic        start1 = 1'b0, rdy1 = 1'b1;
  logic [7:0]  chk1 = 8'h78;
  logic        rom_en1, ram_we1, busy1, dc_en1, err1;
  logic [16:0] rom_a1, ram_a1, boot_p1;
  logic [7:0]  rom_d1 = 8'h00, ram_d1;

  ej32_boot_loader #(.ASZ(17), .BW(1), .ROM_SZ(16), .ROM_WAIT(3),
                     .MEM0(17'h0), .COLD(17'h0), .CHK_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .chk_exp(chk1),
    .rom_en(rom_en1), .rom_a(rom_a1), .rom_d(rom_d1),
    .ram_we(ram_we1), .ram_a(ram_a1), .ram_d(ram_d1), .ram_rdy(rdy1),
    .busy(busy1), .dc_en(dc_en1), .boot_p(boot_p1), .err(err1));

  always_ff @(posedge clk) if (rom_en1) rom_d1 <= rom_a1[7:0];

  // ---------------- DUT 4 ----------------
  logic        start4 = 1'b0, rdy4 = 1'b1;
  logic [7:0]  chk4 = 8'h78;
  logic        rom_en4, ram_we4, busy4, dc_en4, err4;
  logic [16:0] rom_a4, ram_a4, boot_p4;
  logic [31:0] rom_d4 = 32'h0, ram_d4;

  ej32_boot_loader #(.ASZ(17), .BW(4), .ROM_SZ(16), .ROM_WAIT(3),
                     .MEM0(17'h0), .COLD(17'h0), .CHK_EN(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .chk_exp(chk4),
    .rom_en(rom_en4), .rom_a(rom_a4), .rom_d(rom_d4),
    .ram_we(ram_we4), .ram_a(ram_a4), .ram_d(ram_d4), .ram_rdy(rdy4),
    .busy(busy4), .dc_en(dc_en4), .boot_p(boot_p4), .err(err4));

  always_ff @(posedge clk)
    if (rom_en4) rom_d4 <= {rom_a4[7:0] + 8'd3, rom_a4[7:0] + 8'd2, rom_a4[7:0] + 8'd1, rom_a4[7:0]};

  // ---------------- DUT 6 ----------------
  logic        start6 = 1'b0, rdy6 = 1'b1;
  logic [7:0]  chk6 = 8'h78;
  logic        rom_en6, ram_we6, busy6, dc_en6, err6;
  logic [16:0] rom_a6, ram_a6, boot_p6;
  logic [7:0]  rom_d6 = 8'h00, ram_d6;

  ej32_boot_loader #(.ASZ(17), .BW(1), .ROM_SZ(16), .ROM_WAIT(3),
                     .MEM0(17'h1000), .COLD(17'h40), .CHK_EN(1'b1)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .chk_exp(chk6),
    .rom_en(rom_en6), .rom_a(rom_a6), .rom_d(rom_d6),
    .ram_we(ram_we6), .ram_a(ram_a6), .ram_d(ram_d6), .ram_rdy(rdy6),
    .busy(busy6), .dc_en(dc_en6), .boot_p(boot_p6), .err(err6));

  always_ff @(posedge clk) if (rom_en6) rom_d6 <= rom_a6[7:0];

  // ---------------- write monitors ----------------
  // A load starts when address 0 is issued; the write count restarts there.
  int wr_cnt1 = 0, wr_cnt4 = 0, wr_cnt6 = 0;

  function automatic logic [31:0] beat4(input int k);
    logic [7:0] b;
    b = 8'(4 * k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (rom_en1 && rom_a1 == 17'h0) wr_cnt1 = 0;
      if (rom_en4 && rom_a4 == 17'h0) wr_cnt4 = 0;
      if (rom_en6 && rom_a6 == 17'h0) wr_cnt6 = 0;
      if (ram_we1 && rdy1) begin
        check_val("w1_addr", ram_a1, 17'(wr_cnt1));
        check_val("w1_data", ram_d1, 8'(wr_cnt1));
        $display("dut1 write %0d: ram_a=%0h ram_d=%0h", wr_cnt1, ram_a1, ram_d1);
        wr_cnt1++;
      end
      if (ram_we4 && rdy4) begin
        check_val("w4_addr", ram_a4, 17'(4 * wr_cnt4));
        check_val("w4_data", ram_d4, beat4(wr_cnt4));
        $display("dut4 write %0d: ram_a=%0h ram_d=%08h", wr_cnt4, ram_a4, ram_d4);
        wr_cnt4++;
      end
      if (ram_we6 && rdy6) begin
        check_val("w6_addr", ram_a6, 17'h1000 + 17'(wr_cnt6));
        check_val("w6_data", ram_d6, 8'(wr_cnt6));
        $display("dut6 write %0d: ram_a=%0h ram_d=%0h", wr_cnt6, ram_a6, ram_d6);
        wr_cnt6++;
      end
    end
  end

  // Inputs change and outputs are inspected 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic check_reset1(input string tag);
    check_val({tag, "_rom_en"}, rom_en1, 1'b0);
    check_val({tag, "_ram_we"}, ram_we1, 1'b0);
    check_val({tag, "_dc_en"},  dc_en1,  1'b0);
    check_val({tag, "_err"},    err1,    1'b0);
    check_val({tag, "_busy"},   busy1,   1'b1);
    check_val({tag, "_boot_p"}, boot_p1, 17'h0);
    check_val({tag, "_ram_a"},  ram_a1,  17'h0);
  endtask

  int n;
  int held;

  initial begin
    // ---- reset state ----
    tick(); tick();
    check_reset1("rst");
    check_val("rst_ram_a6", ram_a6, 17'h1000);
    check_val("rst_busy4", busy4, 1'b1);

    // ---- tests 1, 2, 6: plain loads; start6 pulsed while dut6 is in COPY ----
    rst = 1'b1;
    tick();                       // first edge after release is cycle 0
    n = 0;
    while (!dc_en1 && n < 100) begin
      tick();
      n++;
      if (n == 8) begin
        check_val("t6_in_copy", ram_we6, 1'b1);
        start6 = 1'b1;
      end
      if (n == 9) start6 = 1'b0;
    end
    $display("load 1: dc_en after %0d cycles", n);
    check_val("t1_cycles", n, 21);          // ROM_WAIT + 18
    check_val("t1_dc_en", dc_en1, 1'b1);
    check_val("t1_err", err1, 1'b0);
    check_val("t1_busy", busy1, 1'b0);
    check_val("t1_boot_p", boot_p1, 17'h0);
    check_val("t1_writes", wr_cnt1, 16);
    check_val("t2_dc_en", dc_en4, 1'b1);
    check_val("t2_writes", wr_cnt4, 4);
    check_val("t6_dc_en", dc_en6, 1'b1);    // same timing: the start pulse was ignored
    check_val("t6_boot_p", boot_p6, 17'h40);
    check_val("t6_writes", wr_cnt6, 16);

    // ---- test 3: stall while ram_a=5 ----
    pulse_start1();
    n = 0;
    while (!(ram_we1 && ram_a1 == 17'd5) && n < 100) begin
      tick();
      n++;
    end
    check_val("t3_reach5", ram_we1 && ram_a1 == 17'd5, 1'b1);
    rdy1 = 1'b0;
    held = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (ram_we1 && ram_a1 == 17'd5) held++;
      if (k == 3) rdy1 = 1'b1;
    end
    $display("stall: ram_a=5 held for %0d cycles", held);
    check_val("t3_held", held, 4);
    tick();
    check_val("t3_next_a", ram_a1, 17'd6);
    n = 0;
    while (!dc_en1 && !err1 && n < 100) begin
      tick();
      n++;
    end
    check_val("t3_dc_en", dc_en1, 1'b1);
    check_val("t3_writes", wr_cnt1, 16);

    // ---- test 4: checksum mismatch, then reload ----
    chk1 = 8'h77;
    pulse_start1();
    n = 0;
    while (!err1 && !dc_en1 && n < 100) begin
      tick();
      n++;
    end
    check_val("t4_err", err1, 1'b1);
    check_val("t4_dc_en", dc_en1, 1'b0);
    check_val("t4_busy", busy1, 1'b0);
    check_val("t4_boot_p", boot_p1, 17'h0);
    chk1 = 8'h78;
    pulse_start1();
    check_val("t4_reload_busy", busy1, 1'b1);
    n = 0;
    while (!dc_en1 && !err1 && n < 100) begin
      tick();
      n++;
    end
    check_val("t4_reload_dc_en", dc_en1, 1'b1);
    check_val("t4_reload_err", err1, 1'b0);
    check_val("t4_reload_writes", wr_cnt1, 16);

    // ---- test 5: reset while ram_a=9 ----
    pulse_start1();
    n = 0;
    while (!(ram_we1 && ram_a1 == 17'd9) && n < 100) begin
      tick();
      n++;
    end
    check_val("t5_reach9", ram_we1 && ram_a1 == 17'd9, 1'b1);
    rst = 1'b0;
    #1;
    check_reset1("t5_rst");
    tick(); tick();
    rst = 1'b1;
    n = 0;
    while (!dc_en1 && !err1 && n < 100) begin
      tick();
      n++;
    end
    check_val("t5_dc_en", dc_en1, 1'b1);
    check_val("t5_writes", wr_cnt1, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
